chunked_adder_sequencer: RTL and testbench
==========================================

// Module: chunked_adder_sequencer
// PURPOSE
//  Multi-cycle N-bit adder front end. It drives a CHUNK-wide combinational adder,
//  such as a conditional_sum_combine tree, one chunk per cycle, starting at the LSB.
//  The chunk carry-out is registered and fed back as the next chunk's carry-in.
//  Operands arrive and results leave through valid/ready handshakes, so wide adds
//  reuse one narrow carry-propagation adder instead of a full-width one.
// PARAMETERS
//  N      32  total operand width in bits
//  CHUNK  8   width of the external adder; N % CHUNK must be 0 and CHUNK >= 1,
//             otherwise elaboration fails
//  NCH    N/CHUNK  derived localparam, number of chunk cycles per add
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept an operand request
//  in_a       in   N      operand A
//  in_b       in   N      operand B
//  in_cin     in   1      carry-in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  out_y      out  N      sum, registered
//  out_cout   out  1      final carry-out, registered
//  add_a      out  CHUNK  current chunk of A, to the external adder
//  add_b      out  CHUNK  current chunk of B, to the external adder
//  add_cin    out  1      carry-in for the current chunk
//  add_y      in   CHUNK  external adder sum, combinational return
//  add_cout   in   1      external adder carry-out, combinational return
// BEHAVIOUR
//  Reset: FSM goes to IDLE. in_ready=1, out_valid=0, out_y=0, out_cout=0.
//    Chunk index k=0, carry register=0, operand registers=0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. When in_valid=1, latch in_a, in_b, in_cin into the carry
//    register, set k=0, go to RUN.
//  RUN: in_ready=0.
//    add_a = a_reg[k*CHUNK +: CHUNK], add_b = b_reg[k*CHUNK +: CHUNK],
//    add_cin = carry register.
//    Each cycle: y_reg[k*CHUNK +: CHUNK] <= add_y, carry <= add_cout, k <= k+1.
//    At k=NCH-1: out_cout <= add_cout, go to DONE with out_valid=1.
//  DONE: out_valid=1; out_y and out_cout stay stable until out_ready=1.
//    in_ready = out_ready, so a new request can be taken in the same cycle as
//    the result handshake.
//    out_ready=1, in_valid=0: go to IDLE.
//    out_ready=1, in_valid=1: latch the new operands, go straight to RUN.
//  Outside RUN, add_a, add_b and add_cin are driven to 0.
//  Latency: request handshake at edge t; out_valid=1 from edge t+NCH.
//    Throughput is one add per NCH+1 cycles with back-to-back traffic.
//  NCH=1: RUN lasts one cycle; there is no special case.
//  k counts 0..NCH-1 and never wraps inside a transaction; it resets to 0 on
//    each accept.
//  in_a, in_b and in_cin changing during RUN or DONE have no effect.
//  out_y keeps its last value after the result handshake until the next result
//    overwrites it.
//  Reset asserted mid-RUN or mid-DONE: all state returns to the reset values at
//    once. The partial result is discarded and out_valid drops asynchronously.
// TESTING (N=16, CHUNK=4, external adder modelled ideally)
//  1. 0x1234 + 0x1111, cin=0 -> out_y=0x2345, out_cout=0; out_valid
//     4 cycles after accept.
//  2. 0xFFFF + 0x0001, cin=0 -> out_y=0x0000, out_cout=1; add_cin=1 on
//     chunks 1..3.
//  3. 0xFFFF + 0x0000, cin=1 -> out_y=0x0000, out_cout=1 (carry-in ripples
//     through every chunk).
//  4. Hold out_ready=0 for 5 cycles in DONE -> out_y and out_valid stable,
//     in_ready=0; then out_ready=1 together with in_valid=1 (0x0F0F + 0xF0F0)
//     -> next result 0xFFFF, cout=0.
//  5. Assert rst_n=0 in the 2nd RUN cycle -> out_valid=0, in_ready=1 at once;
//     a fresh request 0x0001 + 0x0001 gives 0x0002.
//  6. Random operands for 1000 transactions with random in_valid and out_ready
//     -> every result equals {cout,y} = a+b+cin; no result lost or duplicated.

Source files
------------

// File: rtl/chunked_adder_sequencer_if.sv
// Operand request and result handshakes of the chunked adder sequencer.
// The master side issues requests and consumes results; the slave side is the sequencer.
interface chunked_adder_sequencer_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_y, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_y, out_cout
  );
endinterface

// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle N-bit add built from one external CHUNK-wide adder, LSB chunk first,
// with the chunk carry registered between cycles and valid/ready on both ends.
module chunked_adder_sequencer #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_adder_sequencer_if.slave bus,
  output logic [CHUNK-1:0]     add_a_o,
  output logic [CHUNK-1:0]     add_b_o,
  output logic                 add_cin_o,
  input  logic [CHUNK-1:0]     add_y_i,
  input  logic                 add_cout_i
);

  localparam int NCH = N / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("chunked_adder_sequencer: CHUNK must be at least 1");
  end else if (N % CHUNK != 0) begin : g_bad_width
    $error("chunked_adder_sequencer: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   y_q, y_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [KW-1:0]  k_q, k_d;
  logic           accept;
  int             chunk_base;

  // In DONE the result handshake frees the block, so a new request can enter that same cycle.
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_y     = y_q;
  assign bus.out_cout  = cout_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    k_d        = k_q;
    add_a_o    = '0;
    add_b_o    = '0;
    add_cin_o  = 1'b0;
    chunk_base = int'(k_q) * CHUNK;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        add_a_o   = a_q[chunk_base +: CHUNK];
        add_b_o   = b_q[chunk_base +: CHUNK];
        add_cin_o = carry_q;
        y_d[chunk_base +: CHUNK] = add_y_i;
        carry_d   = add_cout_i;
        if (k_q == KLAST) begin
          cout_d  = add_cout_i;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The operand carry-in seeds the chunk carry register, so chunk 0 needs no special case.
    if (accept) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      carry_d = bus.in_cin;
      k_d     = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed and randomised bench for chunked_adder_sequencer at N=16, CHUNK=4,
// with the external chunk adder modelled as an ideal 4-bit adder.
module tb_chunked_adder_sequencer;

  localparam int N     = 16;
  localparam int CHUNK = 4;

  logic             clk;
  logic             rst_n;
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic [CHUNK-1:0] add_y;
  logic             add_cin;
  logic             add_cout;

  int checkCount = 0;
  int errorCount = 0;

  chunked_adder_sequencer_if #(.N(N)) bus ();

  chunked_adder_sequencer #(
    .N    (N),
    .CHUNK(CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .add_a_o   (add_a),
    .add_b_o   (add_b),
    .add_cin_o (add_cin),
    .add_y_i   (add_y),
    .add_cout_i(add_cout)
  );

  assign {add_cout, add_y} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return 1ns after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n;
    n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reqReady", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hDEAD;
    bus.in_b     = 16'hBEEF;
    bus.in_cin   = 1'b1;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic takeResult(input string tag, input logic [15:0] expY, input logic expCout);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_y"}, 32'(bus.out_y), 32'(expY));
    checkOutput({tag, "_cout"}, 32'(bus.out_cout), 32'(expCout));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int           lat;
    int           accepted;
    int           results;
    int           cycles;
    logic         hsIn;
    logic         hsOut;
    logic [16:0]  expQ[$];

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n      = 1'b0;
    #10;

    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_y", 32'(bus.out_y), 32'd0);
    checkOutput("rst_out_cout", 32'(bus.out_cout), 32'd0);
    checkOutput("rst_add_a", 32'(add_a), 32'd0);
    checkOutput("rst_add_cin", 32'(add_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: plain add, latency of NCH cycles after accept
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    checkOutput("t1_busy", 32'(bus.in_ready), 32'd0);
    waitResult(lat);
    checkOutput("t1_latency", 32'(lat), 32'd4);
    takeResult("t1", 16'h2345, 1'b0);
    checkOutput("t1_idle_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t1_idle_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t1_hold_y", 32'(bus.out_y), 32'h2345);

    // Test 2: carry chain through every chunk, observed at the adder port
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_add_a%0d", i), 32'(add_a), 32'hF);
      checkOutput($sformatf("t2_add_b%0d", i), 32'(add_b), (i == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_add_cin%0d", i), 32'(add_cin), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    checkOutput("t2_done_add_cin", 32'(add_cin), 32'd0);
    takeResult("t2", 16'h0000, 1'b1);

    // Test 3: operand carry-in ripples through all chunks
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitResult(lat);
    checkOutput("t3_latency", 32'(lat), 32'd4);
    takeResult("t3", 16'h0000, 1'b1);

    // Test 4: back-pressure in DONE, then result and request handshake in one cycle
    applyStimulus(16'hABCD, 16'h1234, 1'b0);
    waitResult(lat);
    checkOutput("t4_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_valid%0d", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("t4_y%0d", i), 32'(bus.out_y), 32'hBE01);
      checkOutput($sformatf("t4_cout%0d", i), 32'(bus.out_cout), 32'd0);
      checkOutput($sformatf("t4_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h0F0F;
    bus.in_b      = 16'hF0F0;
    bus.in_cin    = 1'b0;
    #1;
    checkOutput("t4_hs_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t4_hs_y", 32'(bus.out_y), 32'hBE01);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("t4_run_valid", 32'(bus.out_valid), 32'd0);
    waitResult(lat);
    checkOutput("t4b_latency", 32'(lat), 32'd4);
    takeResult("t4b", 16'hFFFF, 1'b0);

    // Test 5: asynchronous reset in the second RUN cycle
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t5_rst_y", 32'(bus.out_y), 32'd0);
    checkOutput("t5_rst_add_a", 32'(add_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    waitResult(lat);
    checkOutput("t5_latency", 32'(lat), 32'd4);
    takeResult("t5", 16'h0002, 1'b0);

    // Test 6: random traffic against a FIFO of expected sums
    accepted = 0;
    results  = 0;
    cycles   = 0;
    while ((accepted < 1000 || expQ.size() > 0) && cycles < 30000) begin
      @(negedge clk);
      cycles++;
      hsOut = bus.out_valid && bus.out_ready;
      hsIn  = bus.in_valid && bus.in_ready;
      if (hsOut) begin
        checkOutput("rand_queue", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          checkOutput("rand_sum", 32'({bus.out_cout, bus.out_y}), 32'(expQ.pop_front()));
        end
        results++;
      end
      if (hsIn) begin
        expQ.push_back(17'(bus.in_a) + 17'(bus.in_b) + 17'(bus.in_cin));
        accepted++;
      end
      tick();
      if (hsIn || !bus.in_valid) begin
        if (accepted < 1000) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_a     = 16'($urandom);
          bus.in_b     = 16'($urandom);
          bus.in_cin   = 1'($urandom_range(0, 1));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = (accepted >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("rand_accepted", 32'(accepted), 32'd1000);
    checkOutput("rand_results", 32'(results), 32'd1000);
    checkOutput("rand_left", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
